cc_environment: RTL and testbench

Road-environment generator for the 8x8 Road Fighter matrix. It holds the eight environment rows (row 7 at the top, row 0 at the bottom, next to the car) and scrolls them down one row per game tick. Each new top row carries road walls and at most one obstacle drawn from an LFSR. Its eight row buses feed the environment inputs of the joiner stage, which overlays the car on row 0.

---
 rtl/cc_environment.sv | 138 +++++++++++++
 tb/tb_cc_environment.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cc_environment.sv
// cc_environment: road-environment generator for the 8x8 Road Fighter matrix.
// Holds eight environment rows (fila7 = top, fila0 = bottom next to the car).
// On each game tick it scrolls the rows down by one and loads a new top row.
// The new row always has walls in columns 7 and 0, and may carry one obstacle
// picked from an 8-bit Galois LFSR.
// Optional feature: define CC_ENVIRONMENT_GAP_EN to force a free row between
// obstacle rows. A 1-bit phase alternates rows with and without obstacles.
module cc_environment #(
    parameter logic [23:0] TICK_MAX  = 24'd5_000_000,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic       CC_ENVIRONMENT_CLOCK_50,
    input  logic       CC_ENVIRONMENT_RESET_InHigh,
    input  logic       CC_ENVIRONMENT_run_in,
    input  logic       CC_ENVIRONMENT_clear_in,
    input  logic [1:0] CC_ENVIRONMENT_speed_in,
    output logic [7:0] CC_ENVIRONMENT_fila7_bus_out,
    output logic [7:0] CC_ENVIRONMENT_fila6_bus_out,
    output logic [7:0] CC_ENVIRONMENT_fila5_bus_out,
    output logic [7:0] CC_ENVIRONMENT_fila4_bus_out,
    output logic [7:0] CC_ENVIRONMENT_fila3_bus_out,
    output logic [7:0] CC_ENVIRONMENT_fila2_bus_out,
    output logic [7:0] CC_ENVIRONMENT_fila1_bus_out,
    output logic [7:0] CC_ENVIRONMENT_fila0_bus_out,
    output logic       CC_ENVIRONMENT_scroll_out,
    output logic [7:0] CC_ENVIRONMENT_score_out
);

    localparam logic [7:0] BLANK_ROW = 8'h81;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Short local aliases for the long port names
    logic clk, rst;
    assign clk = CC_ENVIRONMENT_CLOCK_50;
    assign rst = CC_ENVIRONMENT_RESET_InHigh;

    logic [23:0] cnt_q, cnt_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [7:0]  score_q, score_d;
    logic        scroll_q, scroll_d;
    logic [7:0]  rows_q [8];
    logic [7:0]  rows_d [8];
    logic [23:0] limit;
    logic        tick;
    logic [2:0]  idx;
    logic [7:0]  obst_row;
    logic [7:0]  new_row;

    // Scroll period shrinks by powers of two as speed rises
    assign limit = TICK_MAX >> CC_ENVIRONMENT_speed_in;

    // Terminal count; >= keeps a lowered limit from letting the counter run past it
    assign tick = CC_ENVIRONMENT_run_in && (cnt_q >= (limit - 24'd1));

    // Obstacle column from the current LFSR value; 0 and 7 are the walls, so no obstacle
    assign idx = lfsr_q[2:0];
    always_comb begin
        obst_row = BLANK_ROW;
        if (idx != 3'd0 && idx != 3'd7)
            obst_row = BLANK_ROW | (8'h01 << idx);
    end

`ifdef CC_ENVIRONMENT_GAP_EN
    logic phase_q, phase_d;

    // Obstacle only on alternate rows, so there is always a free row between them
    assign new_row = phase_q ? obst_row : BLANK_ROW;

    // Gap phase flips on every scroll; clear restores phase 0
    always_comb begin
        phase_d = phase_q;
        if (CC_ENVIRONMENT_clear_in) phase_d = 1'b0;
        else if (tick)               phase_d = ~phase_q;
    end

    // Gap phase register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) phase_q <= 1'b0;
        else     phase_q <= phase_d;
    end
`else
    assign new_row = obst_row;
`endif

    // Next-state logic: clear wins over a simultaneous scroll
    always_comb begin
        cnt_d    = cnt_q;
        lfsr_d   = lfsr_q;
        score_d  = score_q;
        scroll_d = 1'b0;
        for (int i = 0; i < 8; i++) rows_d[i] = rows_q[i];

        if (CC_ENVIRONMENT_clear_in) begin
            cnt_d   = 24'd0;
            lfsr_d  = LFSR_SEED;
            score_d = 8'd0;
            for (int i = 0; i < 8; i++) rows_d[i] = BLANK_ROW;
        end else if (tick) begin
            cnt_d    = 24'd0;
            scroll_d = 1'b1;
            lfsr_d   = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 8'h00);
            score_d  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
            for (int i = 0; i < 7; i++) rows_d[i] = rows_q[i+1];
            rows_d[7] = new_row;
        end else if (CC_ENVIRONMENT_run_in) begin
            cnt_d = cnt_q + 24'd1;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= 24'd0;
            lfsr_q   <= LFSR_SEED;
            score_q  <= 8'd0;
            scroll_q <= 1'b0;
            for (int i = 0; i < 8; i++) rows_q[i] <= BLANK_ROW;
        end else begin
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            score_q  <= score_d;
            scroll_q <= scroll_d;
            for (int i = 0; i < 8; i++) rows_q[i] <= rows_d[i];
        end
    end

    assign CC_ENVIRONMENT_fila7_bus_out = rows_q[7];
    assign CC_ENVIRONMENT_fila6_bus_out = rows_q[6];
    assign CC_ENVIRONMENT_fila5_bus_out = rows_q[5];
    assign CC_ENVIRONMENT_fila4_bus_out = rows_q[4];
    assign CC_ENVIRONMENT_fila3_bus_out = rows_q[3];
    assign CC_ENVIRONMENT_fila2_bus_out = rows_q[2];
    assign CC_ENVIRONMENT_fila1_bus_out = rows_q[1];
    assign CC_ENVIRONMENT_fila0_bus_out = rows_q[0];
    assign CC_ENVIRONMENT_scroll_out    = scroll_q;
    assign CC_ENVIRONMENT_score_out     = score_q;

endmodule

// File: tb/tb_cc_environment.sv
// Directed bench for cc_environment with TICK_MAX = 8 and seed A5.
module tb_cc_environment;

    logic       clk = 1'b0;
    logic       rst, run, clr;
    logic [1:0] speed;
    logic [7:0] f7, f6, f5, f4, f3, f2, f1, f0, score;
    logic       scroll;

    int vecs = 0;
    int errs = 0;
    int n;
    int pulses;

`ifdef CC_ENVIRONMENT_GAP_EN
    localparam logic [7:0] ROW1 = 8'h81;   // phase 0: no obstacle
    localparam logic [7:0] ROW2 = 8'h85;   // lfsr EA, phase 1, idx 2
`else
    localparam logic [7:0] ROW1 = 8'hA1;   // lfsr A5, idx 5
    localparam logic [7:0] ROW2 = 8'h85;   // lfsr EA, idx 2
`endif

    cc_environment #(.TICK_MAX(24'd8), .LFSR_SEED(8'hA5)) dut (
        .CC_ENVIRONMENT_CLOCK_50      (clk),
        .CC_ENVIRONMENT_RESET_InHigh  (rst),
        .CC_ENVIRONMENT_run_in        (run),
        .CC_ENVIRONMENT_clear_in      (clr),
        .CC_ENVIRONMENT_speed_in      (speed),
        .CC_ENVIRONMENT_fila7_bus_out (f7),
        .CC_ENVIRONMENT_fila6_bus_out (f6),
        .CC_ENVIRONMENT_fila5_bus_out (f5),
        .CC_ENVIRONMENT_fila4_bus_out (f4),
        .CC_ENVIRONMENT_fila3_bus_out (f3),
        .CC_ENVIRONMENT_fila2_bus_out (f2),
        .CC_ENVIRONMENT_fila1_bus_out (f1),
        .CC_ENVIRONMENT_fila0_bus_out (f0),
        .CC_ENVIRONMENT_scroll_out    (scroll),
        .CC_ENVIRONMENT_score_out     (score)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; sample 1 time unit after the rising edge
    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick1();
    endtask

    task automatic chk_blank(input string tag);
        chk({tag, "_f7"}, f7, 8'h81); chk({tag, "_f6"}, f6, 8'h81);
        chk({tag, "_f5"}, f5, 8'h81); chk({tag, "_f4"}, f4, 8'h81);
        chk({tag, "_f3"}, f3, 8'h81); chk({tag, "_f2"}, f2, 8'h81);
        chk({tag, "_f1"}, f1, 8'h81); chk({tag, "_f0"}, f0, 8'h81);
    endtask

    // Clocks until the next scroll pulse, 0 if none within the bound
    task automatic wait_pulse(output int cnt);
        cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            tick1();
            if (scroll) begin cnt = i; break; end
        end
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; clr = 1'b0; speed = 2'd0;
        ticks(2);
        rst = 1'b0; run = 1'b1;
        ticks(3);

        // Asynchronous reset mid-period, checked before any clock edge
        #2 rst = 1'b1;
        #1;
        chk_blank("rst");
        chk("rst_score", score, 8'd0);
        chk("rst_scroll", scroll, 1'b0);
        tick1();
        rst = 1'b0;

        // First scroll exactly 8 clocks after release
        wait_pulse(n);
        chk("first_period", n, 8);
        chk("s1_f7", f7, ROW1);
        chk("s1_f6", f6, 8'h81);
        chk("s1_score", score, 8'd1);
        tick1();
        chk("pulse_width", scroll, 1'b0);

        // Second scroll; fila6 now holds the previous top row
        ticks(7);
        chk("s2_scroll", scroll, 1'b1);
        chk("s2_f7", f7, ROW2);
        chk("s2_f6", f6, ROW1);
        chk("s2_f5", f5, 8'h81);
        chk("s2_score", score, 8'd2);

        // Freeze for 20 clocks
        run = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick1();
            if (scroll) pulses++;
        end
        chk("frz_pulses", pulses, 0);
        chk("frz_f7", f7, ROW2);
        chk("frz_f6", f6, ROW1);
        chk("frz_score", score, 8'd2);

        // Speed 3: limit 1, a scroll every clock
        run = 1'b1; speed = 2'd3;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick1();
            if (scroll) pulses++;
        end
        chk("spd3_pulses", pulses, 4);
        chk("spd3_score", score, 8'd6);
        chk("spd3_f3", f3, ROW2);
        chk("spd3_f2", f2, ROW1);

        // Speed 1: limit 4
        speed = 2'd1;
        wait_pulse(n);
        chk("spd1_period_a", n, 4);
        wait_pulse(n);
        chk("spd1_period_b", n, 4);

        // Clear restores the reset image
        speed = 2'd0; clr = 1'b1;
        tick1();
        clr = 1'b0;
        chk_blank("clr");
        chk("clr_score", score, 8'd0);

        // Clear on the terminal-count edge beats the scroll
        ticks(7);
        chk("tc_pre_scroll", scroll, 1'b0);
        clr = 1'b1;
        tick1();
        clr = 1'b0;
        chk("tc_scroll", scroll, 1'b0);
        chk_blank("tc");
        chk("tc_score", score, 8'd0);
        // Counter and LFSR restarted: full period, seed-derived row
        wait_pulse(n);
        chk("tc_period", n, 8);
        chk("tc_f7", f7, ROW1);
        chk("tc_score1", score, 8'd1);

        // Score saturation at speed 3
        clr = 1'b1;
        tick1();
        clr = 1'b0; speed = 2'd3;
        ticks(254);
        chk("sat_254", score, 8'hFE);
        tick1();
        chk("sat_255", score, 8'hFF);
        ticks(45);
        chk("sat_300", score, 8'hFF);
        chk("sat_scroll", scroll, 1'b1);
        // Rows keep scrolling: ROW1/ROW2 were the first two of 300 new rows,
        // long gone, and the top row is still a walled row
        chk("sat_walls", f7 & 8'h81, 8'h81);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
